// File: rtl/pico_alu_arbiter_pkg.sv
// picorv32_pkg: shared ALU opcodes, requester count and response-slot states.
package picorv32_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/pico_alu_arbiter_if.sv
// pico_alu_arbiter_if: two requester channels plus the response channel of the shared ALU.
interface pico_alu_arbiter_if;

    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic [3:0]  r0_op;
    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [3:0]  r1_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_op,
        input  r1_valid, r1_a, r1_b, r1_op,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_op,
        output r1_valid, r1_a, r1_b, r1_op,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/pico_alu_arbiter_alu.sv
// picorv32_alu: combinational ALU; opcodes outside alu_op_e yield zero.
module picorv32_alu
    import picorv32_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            default:  y = 32'd0;
        endcase
    end

endmodule

// File: rtl/pico_alu_arbiter.sv
// pico_alu_arbiter: round-robin sharing of one ALU between two requesters with a 1-entry response slot.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module pico_alu_arbiter
    import picorv32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    pico_alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    slot_e       state;
    logic        last;
    logic        free;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;

    // last=1 means requester 1 won the previous accept, so requester 0 wins a tie.
    assign free   = state == SLOT_EMPTY || bus.rsp_ready;
    assign gnt0   = bus.r0_valid && (!bus.r1_valid || last);
    assign gnt1   = bus.r1_valid && (!bus.r0_valid || !last);
    assign bus.r0_ready = !rst && free && gnt0;
    assign bus.r1_ready = !rst && free && gnt1;
    assign accept = bus.r0_ready || bus.r1_ready;
    assign bus.rsp_valid = state == SLOT_FULL;

    assign alu_a  = gnt1 ? bus.r1_a  : bus.r0_a;
    assign alu_b  = gnt1 ? bus.r1_b  : bus.r0_b;
    assign alu_op = gnt1 ? bus.r1_op : bus.r0_op;

    picorv32_alu u_alu (
        .op(alu_op),
        .a (alu_a),
        .b (alu_b),
        .y (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SLOT_EMPTY;
            bus.rsp_id   <= 1'b0;
            bus.rsp_data <= 32'd0;
            last         <= 1'b1;
        end else if (accept) begin
            state        <= SLOT_FULL;
            bus.rsp_id   <= gnt1;
            bus.rsp_data <= alu_y;
            last         <= gnt1;
        end else if (bus.rsp_ready) begin
            state        <= SLOT_EMPTY;
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (bus.r0_ready && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (bus.r1_ready && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pico_alu_arbiter.sv
// tb_pico_alu_arbiter: directed and randomized checks against a transaction-level model.
module tb_pico_alu_arbiter;
    import picorv32_pkg::*;

`ifdef ALU_ARB_PERF_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic        m_full = 1'b0;
    logic        m_id = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic        m_last = 1'b1;
    int          c0 = 0;
    int          c1 = 0;

    pico_alu_arbiter_if bus ();

`ifdef ALU_ARB_PERF_EN
    logic [CW-1:0] gnt_cnt0;
    logic [CW-1:0] gnt_cnt1;
`endif

    pico_alu_arbiter #(.CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ALU_ARB_PERF_EN
        ,
        .gnt_cnt0(gnt_cnt0),
        .gnt_cnt1(gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if (op == 4'd0) return a + b;
        if (op == 4'd1) return a - b;
        if (op == 4'd2) return a & b;
        if (op == 4'd3) return a | b;
        if (op == 4'd4) return a ^ b;
        if (op == 4'd5) return a << sh;
        if (op == 4'd6) return a >> sh;
        if (op == 4'd7) return 32'($signed(a) >>> sh);
        if (op == 4'd8) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op == 4'd9) return (a < b) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check readies before the edge, advance model, check response after.
    task automatic step(input logic r, input logic v0, input logic [3:0] o0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic v1, input logic [3:0] o1,
                        input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        logic free, e0, e1;
        rst = r;
        bus.r0_valid = v0; bus.r0_op = o0; bus.r0_a = a0; bus.r0_b = b0;
        bus.r1_valid = v1; bus.r1_op = o1; bus.r1_a = a1; bus.r1_b = b1;
        bus.rsp_ready = rr;
        free = !m_full || rr;
        e0 = !r && free && v0 && (!v1 || m_last);
        e1 = !r && free && v1 && (!v0 || !m_last);
        #1;
        chk("r0_ready", {31'd0, bus.r0_ready}, {31'd0, e0});
        chk("r1_ready", {31'd0, bus.r1_ready}, {31'd0, e1});
        @(posedge clk);
        if (r) begin
            m_full = 1'b0; m_id = 1'b0; m_data = 32'd0; m_last = 1'b1; c0 = 0; c1 = 0;
        end else if (e0 || e1) begin
            m_full = 1'b1;
            m_id = e1;
            m_data = e1 ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
            m_last = e1;
            if (e0 && c0 < CMAX) c0++;
            if (e1 && c1 < CMAX) c1++;
        end else if (rr) begin
            m_full = 1'b0;
        end
        #1;
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_full});
        if (m_full) begin
            chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, m_id});
            chk("rsp_data", bus.rsp_data, m_data);
        end
`ifdef ALU_ARB_PERF_EN
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(c0));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(c1));
`endif
    endtask

    task automatic idle(input logic r, input logic rr);
        step(r, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, rr);
    endtask

    initial begin
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);

        step(1'b0, 1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("acc_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("acc_data", bus.rsp_data, 32'd12);
        idle(1'b0, 1'b1);

        idle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, ALU_SUB, 32'd10, 32'd3, 1'b1, ALU_AND, 32'hF0, 32'h3C, 1'b1);
            chk("tie_id", {31'd0, bus.rsp_id}, 32'(i % 2));
            chk("tie_data", bus.rsp_data, (i % 2) ? 32'h30 : 32'd7);
        end
        idle(1'b0, 1'b1);

        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, ALU_ADD, 32'd1, 32'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, ALU_OR, 32'd8, 32'd1, 1'b1, ALU_XOR, 32'd3, 32'd1, 1'b0);
            chk("bp_data", bus.rsp_data, 32'd2);
        end
        step(1'b0, 1'b1, ALU_OR, 32'd8, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("bp_refill", bus.rsp_data, 32'd9);
        idle(1'b0, 1'b1);

        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, ALU_SLL, 32'd1, 32'd4, 1'b0);
        idle(1'b1, 1'b0);
        chk("rst_mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step(1'b0, 1'b1, ALU_SLTU, 32'd1, 32'd2, 1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd0, 1'b1);
        chk("rst_mid_tie", {31'd0, bus.rsp_id}, 32'd0);

        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'hF, 32'd1, 32'd1, 1'b1);
        chk("undef_id", {31'd0, bus.rsp_id}, 32'd1);
        chk("undef_data", bus.rsp_data, 32'd0);
        idle(1'b0, 1'b1);

`ifdef ALU_ARB_PERF_EN
        idle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, ALU_ADD, 32'(i), 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("sat_cnt0", 32'(gnt_cnt0), 32'd3);
        chk("sat_cnt1", 32'(gnt_cnt1), 32'd0);
`endif

        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom_range(0, 15)), $urandom,
                 (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom),
                 1'($urandom), 4'($urandom_range(0, 15)), $urandom, $urandom,
                 ($urandom_range(0, 9) < 7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pico_alu_arbiter.md
PICO_ALU_ARBITER -- requirements
Module: pico_alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the per-requester grant counters.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 r0_valid  input  1  SHALL indicate that requester 0 presents an operation.
REQ-005 r0_ready  output  1  SHALL indicate that requester 0's operation is accepted this cycle.
REQ-006 r0_a, r0_b  input  32 each  SHALL carry the requester 0 operands.
REQ-007 r0_op  input  4  SHALL carry the requester 0 ALU opcode (alu_op_e).
REQ-008 r1_valid, r1_ready, r1_a, r1_b, r1_op SHALL mirror REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  SHALL indicate that the response register holds a result.
REQ-010 rsp_ready  input  1  SHALL indicate that the consumer takes the response this cycle.
REQ-011 rsp_id  output  1  SHALL give the requester index that owns the response.
REQ-012 rsp_data  output  32  SHALL carry the ALU result.
REQ-013 gnt_cnt0, gnt_cnt1  output  CNT_W each  SHALL exist only under REQ-031 and count accepted operations.

Function
REQ-014 The block SHALL share one combinational ALU between two requesters, accepting at most one operation per cycle.
REQ-015 The response slot SHALL be a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 The slot SHALL be free when it is EMPTY, or FULL with rsp_ready=1.
REQ-017 Grant, when only one requester is valid, SHALL go to that requester.
REQ-018 Grant, when both are valid, SHALL go to the requester not granted at the last accepted transfer (round-robin).
REQ-019 rN_ready SHALL be 1 only for the granted requester and only when the slot is free; the other ready SHALL be 0.
REQ-020 An accept (rN_valid & rN_ready) SHALL load the ALU result of that requester's operands and op, plus its id, into the response register next cycle; latency is exactly 1 cycle.
REQ-021 The last-grant pointer SHALL update only on an accept, never on an offered but unaccepted request.
REQ-022 FSM transitions: EMPTY -> FULL on accept; FULL -> EMPTY on rsp_ready without accept; FULL -> FULL on rsp_ready with accept (back-to-back, full throughput); FULL held otherwise.
REQ-023 While FULL and rsp_ready=0, rsp_valid, rsp_id and rsp_data SHALL remain stable, and both readies SHALL be 0.
REQ-024 Ready SHALL depend combinationally on valid and rsp_ready only; no ready-to-valid loop exists.
REQ-025 A continuously valid requester SHALL be accepted within 2 accepted transfers (starvation bound).
REQ-026 Opcodes undefined in alu_op_e SHALL produce rsp_data = 0 and still complete normally.

Reset
REQ-027 rst=1 SHALL force: FSM EMPTY, rsp_valid=0, rsp_id=0, rsp_data=0, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-028 While rst=1, r0_ready and r1_ready SHALL be 0; a result held mid-operation SHALL be discarded.
REQ-029 The grant counters, when present, SHALL reset to 0.
REQ-030 The first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-031 Macro ALU_ARB_PERF_EN defined: gnt_cnt0/gnt_cnt1 SHALL increment by 1 on each accept of their requester and saturate at all-ones; undefined: the ports and counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-032 The alu_op_e enum (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU) and the requester-count constant SHALL live in the shared picorv32_pkg.
REQ-033 The block SHALL instantiate exactly one picorv32_alu sub-module, fed through the grant mux.

Verification
REQ-034 Accept: reset, then r0 ADD a=5 b=7 held valid, rsp_ready=1 -> r0_ready=1 in cycle 0; rsp_valid=1, rsp_id=0, rsp_data=12 in cycle 1.
REQ-035 Tie: r0 SUB 10,3 and r1 AND 0xF0,0x3C both held valid, rsp_ready=1 -> responses alternate id 0,1,0,1 with data 7, 0x30 each cycle.
REQ-036 Backpressure: r1 ADD 1,1 accepted, rsp_ready=0 for 3 cycles -> rsp_data=2 stable, both readies 0; rsp_ready=1 -> slot drains or refills the same cycle.
REQ-037 Reset mid-operation: FULL with rsp_ready=0, assert rst for 1 cycle -> rsp_valid=0 next cycle; the next tie grants r0.
REQ-038 ALU_ARB_PERF_EN with CNT_W=2: r0 accepted 5 times -> gnt_cnt0 = 3 (saturated), gnt_cnt1 = 0.
REQ-039 Undefined op 4'hF from r1, a=1 b=1 -> rsp_data=0, rsp_id=1, handshake completes normally.
